// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one multi-cycle ALU between two requesters. An idle arbiter accepts
//   one request (round-robin on contention), launches the ALU with a one-cycle
//   start pulse, waits for alu_done or a timeout, then returns a one-cycle
//   response tagged with the requester id.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake (ready only in IDLE)
//   reqN_op / reqN_a / reqN_b      opcode and operands of requester N
//   alu_start                      one-cycle launch pulse to the ALU
//   alu_op / alu_a / alu_b         captured operation, stable while outstanding
//   alu_done / alu_result          ALU completion and result
//   rsp_valid                      one-cycle response pulse
//   rsp_id / rsp_data / rsp_err    response fields, held between responses
//   busy                           arbiter not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 255  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       alu_start,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  // Counter value in the last WAIT cycle that may still see alu_done.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q;
  logic       grant_q;      // requester owning the outstanding operation
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic [7:0] cnt_q;
  logic       rsp_id_q, rsp_err_q;
  logic [7:0] rsp_data_q;

  logic any_valid, grant_sel, accept, wait_tmo;

  assign any_valid = req0_valid | req1_valid;
  // On contention the requester that was not granted last time wins.
  assign grant_sel = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign accept    = (state_q == S_IDLE) && !rst && any_valid;
  // alu_done takes priority over the timeout in the same cycle.
  assign wait_tmo  = (state_q == S_WAIT) && !alu_done && (cnt_q == LAST_WAIT);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (alu_done || wait_tmo) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; every output is forced low while reset is asserted.
  always_comb begin
    req0_ready = accept & ~grant_sel;
    req1_ready = accept &  grant_sel;
    alu_start  = 1'b0;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy      = (state_q != S_IDLE);
      alu_start = (state_q == S_ISSUE);
      rsp_valid = (state_q == S_RESP);
      rsp_id    = rsp_id_q;
      rsp_data  = rsp_data_q;
      rsp_err   = rsp_err_q;
      if (state_q != S_IDLE) begin
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
      end
    end
  end

  // Holding registers, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      grant_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        grant_q      <= grant_sel;
        last_grant_q <= grant_sel;
        op_q         <= grant_sel ? req1_op : req0_op;
        a_q          <= grant_sel ? req1_a  : req0_a;
        b_q          <= grant_sel ? req1_b  : req0_b;
      end
      if (state_q == S_ISSUE) cnt_q <= '0;
      if (state_q == S_WAIT) begin
        if (alu_done) begin
          rsp_id_q   <= grant_q;
          rsp_data_q <= alu_result;
          rsp_err_q  <= 1'b0;
        end else if (wait_tmo) begin
          rsp_id_q   <= grant_q;
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end else begin
          // Never wraps: WAIT is left once the count hits LAST_WAIT.
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles waited for alu_done after alu_start (legal range 1..255).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op / req0_a / req0_b  input  3 / 8 / 8  requester 0 opcode and operands.
REQ-007 req1_valid, req1_ready, req1_op, req1_a, req1_b  as REQ-004..006 for requester 1.
REQ-008 alu_start  output  1  one-cycle pulse launching the shared ALU.
REQ-009 alu_op / alu_a / alu_b  output  3 / 8 / 8  operation presented to the ALU.
REQ-010 alu_done  input  1  ALU result valid this cycle.
REQ-011 alu_result  input  8  ALU result, sampled when alu_done=1.
REQ-012 rsp_valid  output  1  one-cycle response pulse; no backpressure.
REQ-013 rsp_id  output  1  requester the response belongs to.
REQ-014 rsp_data  output  8  result returned to requester.
REQ-015 rsp_err  output  1  1 = ALU timed out, rsp_data forced to 0.
REQ-016 busy  output  1  1 in any state other than IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-018 IDLE: no valid -> stay; any valid -> select winner, assert that reqN_ready combinationally in the same cycle, capture op/a/b into holding registers, go ISSUE.
REQ-019 Arbitration: single valid -> that one wins; both valid -> winner is requester != last_grant; last_grant updates on acceptance.
REQ-020 reqN_ready is 0 in every state except IDLE, and at most one ready is high per cycle.
REQ-021 ISSUE: alu_start=1 for exactly one cycle; clear timeout counter; go WAIT.
REQ-022 alu_op/alu_a/alu_b drive the holding registers continuously from ISSUE through RESP; stable while operation outstanding.
REQ-023 WAIT: alu_done=1 -> capture alu_result, err=0, go RESP; else increment 8-bit counter.
REQ-024 WAIT: counter reaching TIMEOUT with alu_done=0 -> data=0, err=1, go RESP.
REQ-025 alu_done and timeout in same cycle -> alu_done wins (err=0, result captured).
REQ-026 alu_done outside WAIT ignored, no state effect.
REQ-027 RESP: rsp_valid=1 one cycle with rsp_id=granted requester, rsp_data, rsp_err; go IDLE.
REQ-028 rsp_id/rsp_data/rsp_err hold last response values when rsp_valid=0.
REQ-029 Latency: accept at cycle T, alu_start at T+1, earliest alu_done sampled T+2, rsp_valid at T+3; next accept earliest T+4.
REQ-030 Request inputs change while not ready have no effect; captured operands unaffected by later input changes.
REQ-031 Counter saturates only by leaving WAIT; no wrap-around possible.

Reset
REQ-032 rst=1 at rising edge: state IDLE, last_grant=1 (requester 0 wins first contention), counter 0, holding registers 0.
REQ-033 During and after reset: all outputs 0 (ready, alu_start, alu_op/a/b, rsp_valid, rsp_id, rsp_data, rsp_err, busy).
REQ-034 Reset mid-operation abandons the operation; no rsp_valid emitted for it; late alu_done ignored.

Verification
REQ-035 Single op: req0 op=0 a=8'h05 b=8'h03, ALU done 1 cycle after start, result 8'h08 -> req0_ready at T, alu_start T+1, rsp_valid T+3, rsp_id=0, rsp_data=8'h08, rsp_err=0.
REQ-036 Contention: both valid continuously from reset -> grants 0,1,0,1; rsp_id alternates; no requester served twice consecutively.
REQ-037 Timeout: TIMEOUT=4, alu_done never asserted -> rsp_valid with rsp_err=1, rsp_data=0, 4 WAIT cycles after start; returns IDLE.
REQ-038 Race: TIMEOUT=4, alu_done on exactly the timeout cycle with result 8'hA5 -> rsp_err=0, rsp_data=8'hA5.
REQ-039 Reset in WAIT: rst pulsed one cycle, then alu_done -> no rsp_valid, all outputs 0, busy=0, next contention grants requester 0.
REQ-040 Operand stability: change req0_a/b after acceptance -> alu_a/alu_b keep captured values until RESP completes.
